reg_file_param: RTL

REG_FILE_PARAM -- requirements
Module: reg_file_param

---
 rtl/reg_file_param.sv | 87 ++++++++
 1 files changed

// File: rtl/reg_file_param.sv
// Parameterised register file whose entry 0 is the PC, with a per-register
// pending scoreboard. Reads are combinational and see in-flight general writes.
module reg_file_param #(
    parameter int                DATA_W = 16,
    parameter int                ADDR_W = 3,
    parameter logic [DATA_W-1:0] PC_RST = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              busy1,
    output logic              busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pc_we,
    input  logic [DATA_W-1:0] pc_in,
    output logic [DATA_W-1:0] pc_out,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    output logic              any_busy
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   sb_q;
    logic [NREG-1:0]   sb_d;

    logic wr_valid;
    logic sb_valid;
    logic hit1;
    logic hit2;

    // Register 0 is reserved for the PC, so general writes and scoreboard
    // sets aimed at it are dropped here.
    assign wr_valid = wr_en && (wr_addr != '0);
    assign sb_valid = sb_set && (sb_addr != '0);
    assign hit1     = wr_valid && (wr_addr == rd_addr1);
    assign hit2     = wr_valid && (wr_addr == rd_addr2);

    // NOTE: every output of this block gets a full default first, so no latch
    // is inferred when none of the write strobes is active.
    always_comb begin
        regs_d = regs_q;
        sb_d   = sb_q;
        if (pc_we) begin
            regs_d[0] = pc_in;
        end
        if (wr_valid) begin
            regs_d[wr_addr] = wr_data;
            sb_d[wr_addr]   = 1'b0;
        end
        // Set is applied after the clear so a same-address set wins.
        if (sb_valid) begin
            sb_d[sb_addr] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    // NOTE: non-blocking assignments for all state. The storage array is reset
    // explicitly because a cleared register file is architecturally visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q[0] <= PC_RST;
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            sb_q <= '0;
        end else begin
            regs_q <= regs_d;
            sb_q   <= sb_d;
        end
    end

    assign rd_data1 = hit1 ? wr_data : regs_q[rd_addr1];
    assign rd_data2 = hit2 ? wr_data : regs_q[rd_addr2];
    assign busy1    = sb_q[rd_addr1] && !hit1;
    assign busy2    = sb_q[rd_addr2] && !hit2;
    assign pc_out   = regs_q[0];
    assign any_busy = |sb_q;

endmodule
